// File: rtl/pe_issue_ctrl.sv
// Single-issue sequencer: decodes PE instructions, dispatches ARITH/ACT ops to
// their execution unit over valid/ready, waits for completion and counts retires.
module pe_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             ar_valid,
    input  logic             ar_ready,
    output logic [4:0]       ar_func,
    output logic [19:0]      ar_operands,
    input  logic             ar_done,
    output logic             ac_valid,
    input  logic             ac_ready,
    output logic [4:0]       ac_func,
    output logic [19:0]      ac_operands,
    input  logic             ac_done,
    output logic             busy,
    output logic             illegal_op,
    output logic             timeout_err,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [6:0]  OP_NOP   = 7'b0000000;
    localparam logic [6:0]  OP_ARITH = 7'b0000001;
    localparam logic [6:0]  OP_ACT   = 7'b0000010;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] instr_q;
    logic [15:0] tmo_cnt;

    logic [6:0] op_in;
    logic       accept;
    logic       in_is_nop;
    logic       in_is_exec;
    logic       in_is_illegal;
    logic       sel_arith;
    logic       unit_valid;
    logic       unit_ready;
    logic       unit_done;
    logic       tmo_hit;
    logic       retire;

    assign op_in         = in_instr[31:25];
    assign accept        = in_valid && in_ready;
    assign in_is_nop     = (op_in == OP_NOP);
    assign in_is_exec    = (op_in == OP_ARITH) || (op_in == OP_ACT);
    assign in_is_illegal = !in_is_nop && !in_is_exec;

    // Only ARITH and ACT ever reach ISSUE/WAIT, so one bit selects the unit.
    assign sel_arith  = (instr_q[31:25] == OP_ARITH);
    assign unit_ready = sel_arith ? ar_ready : ac_ready;
    assign unit_done  = sel_arith ? ar_done  : ac_done;
    assign unit_valid = (state == ISSUE);
    assign tmo_hit    = (tmo_cnt == TMO_LAST);

    assign retire = (accept && in_is_nop) || ((state == WAIT) && unit_done);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && in_is_exec) state_nxt = ISSUE;
            ISSUE:   if (unit_valid && unit_ready) state_nxt = WAIT;
            WAIT:    if (unit_done || tmo_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: dispatch fields are gated so the idle unit sees zeros.
    always_comb begin
        in_ready    = (state == IDLE);
        busy        = (state != IDLE);
        ar_valid    = unit_valid && sel_arith;
        ac_valid    = unit_valid && !sel_arith;
        ar_func     = ar_valid ? instr_q[24:20] : 5'd0;
        ar_operands = ar_valid ? instr_q[19:0]  : 20'd0;
        ac_func     = ac_valid ? instr_q[24:20] : 5'd0;
        ac_operands = ac_valid ? instr_q[19:0]  : 20'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q     <= '0;
            tmo_cnt     <= '0;
            illegal_op  <= 1'b0;
            timeout_err <= 1'b0;
            retired_cnt <= '0;
        end else begin
            if (accept) instr_q <= in_instr;
            // Counter runs only while staying in WAIT; it restarts at 0 on entry.
            if ((state == WAIT) && (state_nxt == WAIT)) tmo_cnt <= tmo_cnt + 16'd1;
            else                                        tmo_cnt <= '0;
            illegal_op  <= accept && in_is_illegal;
            timeout_err <= (state == WAIT) && !unit_done && tmo_hit;
            if (retire) retired_cnt <= retired_cnt + 1'b1;
        end
    end

endmodule

// File: doc/pe_issue_ctrl.md
Name: pe_issue_ctrl

Overview:
- Single-issue sequencer between the PE instruction stream and the PE execution units (arithmetic unit, activation unit).
- Decodes each 32-bit instruction: opcode[31:25], func[24:20], operand field[19:0].
- Dispatches each instruction to the selected unit with a valid/ready handshake, waits for completion, and counts retired instructions.
- Flags illegal opcodes and units that never complete.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in WAIT before abort; legal range 1..65535.
- CNT_W, 16: width of retired_cnt.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction available
- in_ready  out  1  controller accepts instruction this cycle
- in_instr  in  32  instruction word
- ar_valid  out  1  dispatch request to arithmetic unit
- ar_ready  in  1  arithmetic unit accepts
- ar_func  out  5  func field for arithmetic unit
- ar_operands  out  20  instr[19:0] for arithmetic unit
- ar_done  in  1  arithmetic unit completion pulse
- ac_valid  out  1  dispatch request to activation unit
- ac_ready  in  1  activation unit accepts
- ac_func  out  5  func field for activation unit
- ac_operands  out  20  instr[19:0] for activation unit
- ac_done  in  1  activation unit completion pulse
- busy  out  1  state != IDLE
- illegal_op  out  1  one-cycle pulse, illegal opcode dropped
- timeout_err  out  1  one-cycle pulse, WAIT timed out
- retired_cnt  out  CNT_W  retired instruction count

Behaviour:
- Opcode decode:
  - 7'b0000000 = NOP
  - 7'b0000001 = ARITH
  - 7'b0000010 = ACT
  - all other opcodes = illegal
- Reset (synchronous, active-high): state=IDLE, all valids 0, busy 0, illegal_op 0, timeout_err 0, retired_cnt 0, instruction register 0, timeout counter 0. Reset mid-operation aborts the in-flight op; later done pulses are ignored, because done is only sampled in WAIT.
- in_ready = (state==IDLE), combinational from state. An accept occurs when in_valid & in_ready.
- IDLE, on accept: latch in_instr into the instruction register, then
  - ARITH or ACT: go to ISSUE.
  - NOP: stay IDLE; retired_cnt+1 next cycle. Back-to-back NOPs retire 1 per cycle.
  - illegal: stay IDLE; illegal_op=1 next cycle for exactly one cycle; no retire.
- ISSUE: registered ar_valid (ARITH) or ac_valid (ACT) is high; never both.
  - func and operands come from the instruction register and are held stable while valid is high.
  - The other unit's func/operands are driven 0.
  - On valid & ready: go to WAIT; valid deasserts next cycle. Valid stays high until ready; there is no timeout in ISSUE.
- Dispatch latency: instruction accepted in cycle N → unit valid high in cycle N+1.
- WAIT: timeout counter starts at 0 and increments each cycle.
  - Done from the selected unit: go to IDLE, retired_cnt+1.
  - Done from the non-selected unit: ignored.
  - Counter reaches TIMEOUT_CYCLES-1 with no done: go to IDLE, timeout_err pulses 1 cycle, no retire.
  - Done in the same cycle as the timeout: done wins; no error.
- Unit contract: done arrives at least 1 cycle after the accepting handshake cycle. done during ISSUE is ignored.
- retired_cnt wraps modulo 2^CNT_W.
- busy = (state != IDLE), registered with the state.
- Error pulses and retire increments never occur in the same cycle.

Test Plan:
- Reset then idle: after rst, in_ready=1, busy=0, retired_cnt=0, all valids 0 → remain so for 10 cycles with in_valid=0.
- ARITH dispatch: in_instr={7'b0000001,5'b00001,20'h12345}, ar_ready held 0 for 3 cycles, then 1 → ar_valid high 4 cycles with ar_func=5'b00001, ar_operands=20'h12345; ar_done 2 cycles later → retired_cnt=1; in_ready=1 the next cycle.
- ACT routing and cross-done: ACT instr, func=5'b00100 → ac_valid only. ar_done pulse in WAIT is ignored; ac_done then retires → retired_cnt+1.
- Illegal and NOP stream: NOP, 7'b1111111, NOP on consecutive cycles → in_ready stays 1; illegal_op pulses once; retired_cnt=2.
- Timeout: TIMEOUT_CYCLES=8, ARITH accepted, no ar_done → timeout_err one-cycle pulse 8 cycles after entering WAIT; retired_cnt unchanged; IDLE after.
- Reset mid-op plus wrap: rst in WAIT → IDLE, valids 0; late ar_done is ignored. Separately, CNT_W=4 and 17 NOPs → retired_cnt=1.
